// File: rtl/draw_ball_if.sv
// Pixel stream passed between the stages of the video pipeline.
// Fields: hcount/vcount pixel coordinates, hsync/vsync sync pulses,
// hblnk/vblnk blanking flags, rgb 4:4:4 colour.
// master drives the stream, slave consumes it.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_ball.sv
// Ball stage of the Pong pipeline: once per frame moves/bounces the ball,
// detects paddle returns and misses, and overlays the ball on the stream.
// Ports:
//   clk, rst   pixel clock, synchronous active-high reset
//   paddle_y   paddle top line (sampled on frame ticks only)
//   vga        incoming pixel stream
//   vga_out    stream delayed by one cycle with the ball overlaid
//   hit, miss  one-cycle pulses after a paddle return / left-edge miss
module draw_ball #(
  parameter int unsigned H_ACTIVE     = 800,
  parameter int unsigned V_ACTIVE     = 600,
  parameter int unsigned BALL_SIZE    = 16,
  parameter int unsigned BALL_SPEED   = 4,
  parameter int unsigned PADDLE_X     = 32,
  parameter int unsigned PADDLE_W     = 16,
  parameter int unsigned PADDLE_H     = 96,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter logic [11:0] BALL_COLOR   = 12'hFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] paddle_y,
  vga_if.slave        vga,
  vga_if.master       vga_out,
  output logic        hit,
  output logic        miss
);

  localparam int unsigned CNT_W = ($clog2(SERVE_FRAMES) > 7) ? $clog2(SERVE_FRAMES) : 7;

  // 12-bit working constants so that sums never wrap
  localparam logic [11:0] X_CTR  = 12'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] Y_CTR  = 12'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] X_MAX  = 12'(H_ACTIVE - BALL_SIZE);
  localparam logic [11:0] Y_MAX  = 12'(V_ACTIVE - BALL_SIZE);
  localparam logic [11:0] H_LIM  = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIM  = 12'(V_ACTIVE);
  localparam logic [11:0] BS     = 12'(BALL_SIZE);
  localparam logic [11:0] SPD    = 12'(BALL_SPEED);
  localparam logic [11:0] PAD_R  = 12'(PADDLE_X + PADDLE_W);
  localparam logic [11:0] PAD_H  = 12'(PADDLE_H);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  typedef enum logic [0:0] {
    SERVE = 1'b0,
    MOVE  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic [10:0]        x_pos_q, x_pos_d;
  logic [10:0]        y_pos_q, y_pos_d;
  logic               dir_x_q, dir_x_d;
  logic               dir_y_q, dir_y_d;
  logic               vblnk_d_q, vblnk_d_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  logic [10:0]        hcount_q, hcount_d;
  logic [10:0]        vcount_q, vcount_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               hblnk_q, hblnk_d;
  logic               vblnk_q, vblnk_d;
  logic [11:0]        rgb_q, rgb_d;

  logic               tick_c;
  logic               inside_c;
  logic [11:0]        xw, yw, pw, hw, vw;

  // Next-state: frame-rate ball motion and pixel-rate overlay
  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    x_pos_d     = x_pos_q;
    y_pos_d     = y_pos_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    vblnk_d_d   = vga.vblnk;

    xw = {1'b0, x_pos_q};
    yw = {1'b0, y_pos_q};
    pw = {1'b0, paddle_y};
    hw = {1'b0, vga.hcount};
    vw = {1'b0, vga.vcount};

    // Rising edge of vertical blanking marks the frame tick
    tick_c = vga.vblnk & ~vblnk_d_q;

    if (tick_c) begin
      case (state_q)
        SERVE: begin
          x_pos_d = 11'(X_CTR);
          y_pos_d = 11'(Y_CTR);
          if (serve_cnt_q == SERVE_LAST) begin
            serve_cnt_d = '0;
            state_d     = MOVE;
          end else begin
            serve_cnt_d = serve_cnt_q + CNT_W'(1);
          end
        end
        MOVE: begin
          // Y axis first; a miss below overrides it
          if (!dir_y_q) begin
            if (yw <= SPD) begin
              y_pos_d = '0;
              dir_y_d = 1'b1;
            end else begin
              y_pos_d = 11'(yw - SPD);
            end
          end else begin
            if (yw + BS + SPD >= V_LIM) begin
              y_pos_d = 11'(Y_MAX);
              dir_y_d = 1'b0;
            end else begin
              y_pos_d = 11'(yw + SPD);
            end
          end

          if (!dir_x_q) begin
            if ((xw >= PAD_R) && (xw < PAD_R + SPD) &&
                (yw + BS > pw) && (yw < pw + PAD_H)) begin
              x_pos_d = 11'(PAD_R);
              dir_x_d = 1'b1;
              hit_d   = 1'b1;
            end else if (xw <= SPD) begin
              miss_d      = 1'b1;
              state_d     = SERVE;
              x_pos_d     = 11'(X_CTR);
              y_pos_d     = 11'(Y_CTR);
              dir_x_d     = 1'b0;
              dir_y_d     = ~dir_y_q;
              serve_cnt_d = '0;
            end else begin
              x_pos_d = 11'(xw - SPD);
            end
          end else begin
            if (xw + BS + SPD >= H_LIM) begin
              x_pos_d = 11'(X_MAX);
              dir_x_d = 1'b0;
            end else begin
              x_pos_d = 11'(xw + SPD);
            end
          end
        end
        default: state_d = SERVE;
      endcase
    end

    inside_c = (hw >= xw) && (hw < xw + BS) && (vw >= yw) && (vw < yw + BS);

    hcount_d = vga.hcount;
    vcount_d = vga.vcount;
    hsync_d  = vga.hsync;
    vsync_d  = vga.vsync;
    hblnk_d  = vga.hblnk;
    vblnk_d  = vga.vblnk;
    rgb_d    = (inside_c && !vga.hblnk && !vga.vblnk) ? BALL_COLOR : vga.rgb;
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SERVE;
      serve_cnt_q <= '0;
      x_pos_q     <= 11'(X_CTR);
      y_pos_q     <= 11'(Y_CTR);
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b1;
      vblnk_d_q   <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      vblnk_d_q   <= vblnk_d_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      hblnk_q     <= hblnk_d;
      vblnk_q     <= vblnk_d;
      rgb_q       <= rgb_d;
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = rgb_q;
  assign hit            = hit_q;
  assign miss           = miss_q;

endmodule
